// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with two write ports, two read ports
// and a per-register pending scoreboard with a population count.
// Port B (load writeback) takes priority over port A (ALU writeback) on an
// address collision; a claim in the same cycle as a write keeps the register
// pending, because the claim belongs to a newer producer.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wa_en,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic [ADDR_W:0]   busy_cnt_q;
    logic [ADDR_W:0]   busy_cnt_d;

    // Forwarding is suppressed while reset is held so reads show the cleared state.
    logic bypass_en;
    assign bypass_en = (BYPASS != 0) && !rst;

    // Register 0 is hardwired only when ZERO_REG is set.
    function automatic logic is_hardwired(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // Read mux: stored value, optionally overridden by this cycle's write data.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = regs_q[addr];
        if (bypass_en) begin
            if (wb_en && (wb_addr == addr)) begin
                val = wb_data;
            end else if (wa_en && (wa_addr == addr)) begin
                val = wa_data;
            end
        end
        if (is_hardwired(addr)) begin
            val = '0;
        end
        return val;
    endfunction

    // Per-register write decode and pending-bit next state.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            logic hit_a;
            logic hit_b;
            logic hit_c;
            logic locked;
            locked = (ZERO_REG != 0) && (i == 0);
            hit_a  = wa_en    && (wa_addr    == ADDR_W'(i)) && !locked;
            hit_b  = wb_en    && (wb_addr    == ADDR_W'(i)) && !locked;
            hit_c  = claim_en && (claim_addr == ADDR_W'(i)) && !locked;
            if (hit_b) begin
                regs_d[i] = wb_data;
            end else if (hit_a) begin
                regs_d[i] = wa_data;
            end else begin
                regs_d[i] = regs_q[i];
            end
            pend_d[i] = hit_c | (pend_q[i] & ~(hit_a | hit_b));
        end
    end

    // Population count of the next pending vector, so the count moves with the bits.
    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, pend_d[i]};
        end
    end

    // State registers; reset clears everything without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pend_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pend_q     <= pend_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Combinational read ports; busy flags show stored pending bits only.
    always_comb begin
        rd_data1 = read_port(rd_addr1);
        rd_data2 = read_port(rd_addr2);
        rd_busy1 = pend_q[rd_addr1];
        rd_busy2 = pend_q[rd_addr2];
    end

    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

    logic        clk;
    logic        rst;
    logic [4:0]  rd_addr1, rd_addr2;
    logic [31:0] rd_data1, rd_data2;
    logic        rd_busy1, rd_busy2;
    logic        wa_en, wb_en, claim_en;
    logic [4:0]  wa_addr, wb_addr, claim_addr;
    logic [31:0] wa_data, wb_data;
    logic [5:0]  busy_cnt;

    logic [31:0] nb_rd_data1, nb_rd_data2;
    logic        nb_rd_busy1, nb_rd_busy2;
    logic [5:0]  nb_busy_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // reference model
    logic [31:0] mem [32];
    bit          pend [32];

    reg_file_mp dut (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .busy_cnt(busy_cnt)
    );

    reg_file_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(nb_rd_data1), .rd_data2(nb_rd_data2),
        .rd_busy1(nb_rd_busy1), .rd_busy2(nb_rd_busy2),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .busy_cnt(nb_busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            mem[i]  = '0;
            pend[i] = 1'b0;
        end
    endfunction

    // Sequential reading of the rules: writes (B after A so B wins), then claim overrides clear.
    function automatic void model_commit();
        if (rst) begin
            model_reset();
            return;
        end
        if (wa_en && wa_addr != 0) begin mem[wa_addr] = wa_data; pend[wa_addr] = 1'b0; end
        if (wb_en && wb_addr != 0) begin mem[wb_addr] = wb_data; pend[wb_addr] = 1'b0; end
        if (claim_en && claim_addr != 0) pend[claim_addr] = 1'b1;
    endfunction

    function automatic logic [31:0] model_rd(input logic [4:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && !rst) begin
            if (wb_en && wb_addr == a) return wb_data;
            if (wa_en && wa_addr == a) return wa_data;
        end
        return mem[a];
    endfunction

    function automatic logic [5:0] model_cnt();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(pend[i]);
        return 6'(c);
    endfunction

    task automatic idle();
        wa_en = 0; wb_en = 0; claim_en = 0;
        wa_addr = 0; wb_addr = 0; claim_addr = 0;
        wa_data = 0; wb_data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 0;
        idle();
        rd_addr1 = 5; rd_addr2 = 0;
        #1 rst = 1;
        model_reset();
        #1;
        n_checks++; if (busy_cnt !== 6'd0) begin n_errors++; $display("FAIL reset_cnt got=%0d exp=0", busy_cnt); end
        n_checks++; if (rd_data1 !== 32'h0) begin n_errors++; $display("FAIL reset_rd1 got=%h exp=0", rd_data1); end
        n_checks++; if (rd_busy1 !== 1'b0) begin n_errors++; $display("FAIL reset_busy1 got=%b exp=0", rd_busy1); end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_async_reset();
        wa_en = 1; wa_addr = 5; wa_data = 32'h1234;
        claim_en = 1; claim_addr = 6;
        tick();
        idle();
        rd_addr1 = 5; rd_addr2 = 6;
        #1;
        n_checks++; if (rd_data1 !== 32'h1234) begin n_errors++; $display("FAIL ar_load got=%h exp=00001234", rd_data1); end
        n_checks++; if (busy_cnt !== 6'd1) begin n_errors++; $display("FAIL ar_cnt_pre got=%0d exp=1", busy_cnt); end
        #1 rst = 1;
        model_reset();
        #1;
        n_checks++; if (rd_data1 !== 32'h0) begin n_errors++; $display("FAIL ar_rd1 got=%h exp=0", rd_data1); end
        n_checks++; if (busy_cnt !== 6'd0) begin n_errors++; $display("FAIL ar_cnt got=%0d exp=0", busy_cnt); end
        n_checks++; if (rd_busy2 !== 1'b0) begin n_errors++; $display("FAIL ar_busy2 got=%b exp=0", rd_busy2); end
        wa_en = 1; wa_addr = 5; wa_data = 32'h5555;
        claim_en = 1; claim_addr = 6;
        #1;
        n_checks++; if (rd_data1 !== 32'h0) begin n_errors++; $display("FAIL ar_nobypass got=%h exp=0", rd_data1); end
        tick();
        rst = 0;
        idle();
        #1;
        n_checks++; if (rd_data1 !== 32'h0) begin n_errors++; $display("FAIL ar_wr_ignored got=%h exp=0", rd_data1); end
        n_checks++; if (busy_cnt !== 6'd0) begin n_errors++; $display("FAIL ar_claim_ignored got=%0d exp=0", busy_cnt); end
    endtask

    task automatic test_write_read();
        idle();
        wa_en = 1; wa_addr = 3; wa_data = 32'hDEADBEEF;
        rd_addr1 = 3;
        #1;
        n_checks++; if (rd_data1 !== 32'hDEADBEEF) begin n_errors++; $display("FAIL wr_bypass got=%h exp=deadbeef", rd_data1); end
        n_checks++; if (nb_rd_data1 !== 32'h0) begin n_errors++; $display("FAIL wr_nobypass got=%h exp=0", nb_rd_data1); end
        tick();
        idle();
        #1;
        n_checks++; if (rd_data1 !== 32'hDEADBEEF) begin n_errors++; $display("FAIL wr_stored got=%h exp=deadbeef", rd_data1); end
        n_checks++; if (nb_rd_data1 !== 32'hDEADBEEF) begin n_errors++; $display("FAIL wr_nb_stored got=%h exp=deadbeef", nb_rd_data1); end
    endtask

    task automatic test_zero_reg();
        idle();
        wa_en = 1; wa_addr = 0; wa_data = 32'hFFFFFFFF;
        claim_en = 1; claim_addr = 0;
        rd_addr1 = 0;
        #1;
        n_checks++; if (rd_data1 !== 32'h0) begin n_errors++; $display("FAIL zero_bypass got=%h exp=0", rd_data1); end
        tick();
        idle();
        #1;
        n_checks++; if (rd_data1 !== 32'h0) begin n_errors++; $display("FAIL zero_rd got=%h exp=0", rd_data1); end
        n_checks++; if (rd_busy1 !== 1'b0) begin n_errors++; $display("FAIL zero_busy got=%b exp=0", rd_busy1); end
        n_checks++; if (busy_cnt !== 6'd0) begin n_errors++; $display("FAIL zero_cnt got=%0d exp=0", busy_cnt); end
    endtask

    task automatic test_collision();
        idle();
        wa_en = 1; wa_addr = 7; wa_data = 32'h11;
        wb_en = 1; wb_addr = 7; wb_data = 32'h22;
        rd_addr1 = 7;
        #1;
        n_checks++; if (rd_data1 !== 32'h22) begin n_errors++; $display("FAIL coll_bypass got=%h exp=22", rd_data1); end
        tick();
        wa_addr = 8; wa_data = 32'h33;
        wb_addr = 9; wb_data = 32'h44;
        #1;
        n_checks++; if (nb_rd_data1 !== 32'h22) begin n_errors++; $display("FAIL coll_same got=%h exp=22", nb_rd_data1); end
        tick();
        idle();
        rd_addr1 = 8; rd_addr2 = 9;
        #1;
        n_checks++; if (rd_data1 !== 32'h33) begin n_errors++; $display("FAIL coll_a got=%h exp=33", rd_data1); end
        n_checks++; if (rd_data2 !== 32'h44) begin n_errors++; $display("FAIL coll_b got=%h exp=44", rd_data2); end
    endtask

    task automatic test_scoreboard();
        idle();
        claim_en = 1; claim_addr = 4;
        rd_addr1 = 4; rd_addr2 = 4;
        #1;
        n_checks++; if (rd_busy1 !== 1'b0) begin n_errors++; $display("FAIL sb_no_claim_bypass got=%b exp=0", rd_busy1); end
        tick();
        idle();
        #1;
        n_checks++; if (rd_busy1 !== 1'b1) begin n_errors++; $display("FAIL sb_claim got=%b exp=1", rd_busy1); end
        n_checks++; if (busy_cnt !== 6'd1) begin n_errors++; $display("FAIL sb_cnt1 got=%0d exp=1", busy_cnt); end
        wb_en = 1; wb_addr = 4; wb_data = 32'hAB;
        claim_en = 1; claim_addr = 4;
        tick();
        idle();
        #1;
        n_checks++; if (rd_busy1 !== 1'b1) begin n_errors++; $display("FAIL sb_reclaim_busy got=%b exp=1", rd_busy1); end
        n_checks++; if (busy_cnt !== 6'd1) begin n_errors++; $display("FAIL sb_reclaim_cnt got=%0d exp=1", busy_cnt); end
        n_checks++; if (rd_data1 !== 32'hAB) begin n_errors++; $display("FAIL sb_reclaim_data got=%h exp=ab", rd_data1); end
        wa_en = 1; wa_addr = 4; wa_data = 32'hCD;
        #1;
        n_checks++; if (rd_busy2 !== 1'b1) begin n_errors++; $display("FAIL sb_no_clear_bypass got=%b exp=1", rd_busy2); end
        tick();
        idle();
        #1;
        n_checks++; if (rd_busy1 !== 1'b0) begin n_errors++; $display("FAIL sb_release got=%b exp=0", rd_busy1); end
        n_checks++; if (busy_cnt !== 6'd0) begin n_errors++; $display("FAIL sb_release_cnt got=%0d exp=0", busy_cnt); end
        n_checks++; if (rd_data1 !== 32'hCD) begin n_errors++; $display("FAIL sb_release_data got=%h exp=cd", rd_data1); end
    endtask

    task automatic test_saturation();
        idle();
        for (int i = 1; i < 32; i++) begin
            claim_en = 1; claim_addr = 5'(i);
            tick();
        end
        idle();
        rd_addr1 = 31;
        #1;
        n_checks++; if (busy_cnt !== 6'd31) begin n_errors++; $display("FAIL sat_full got=%0d exp=31", busy_cnt); end
        n_checks++; if (rd_busy1 !== 1'b1) begin n_errors++; $display("FAIL sat_busy31 got=%b exp=1", rd_busy1); end
        claim_en = 1; claim_addr = 5;
        tick();
        idle();
        #1;
        n_checks++; if (busy_cnt !== 6'd31) begin n_errors++; $display("FAIL sat_reclaim got=%0d exp=31", busy_cnt); end
        for (int i = 1; i < 32; i++) begin
            idle();
            if (i % 2 == 1) begin wa_en = 1; wa_addr = 5'(i); wa_data = 32'(i * 3); end
            else            begin wb_en = 1; wb_addr = 5'(i); wb_data = 32'(i * 5); end
            tick();
        end
        idle();
        #1;
        n_checks++; if (busy_cnt !== 6'd0) begin n_errors++; $display("FAIL sat_empty got=%0d exp=0", busy_cnt); end
    endtask

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            wa_en = 1'($urandom_range(0, 1)); wa_addr = rand_addr(); wa_data = $urandom();
            wb_en = 1'($urandom_range(0, 1)); wb_addr = rand_addr(); wb_data = $urandom();
            claim_en = 1'($urandom_range(0, 1)); claim_addr = rand_addr();
            rd_addr1 = rand_addr(); rd_addr2 = rand_addr();
            #1;
            n_checks++; if (rd_data1 !== model_rd(rd_addr1, 1)) begin n_errors++; $display("FAIL rnd_rd1 cyc=%0d a=%0d got=%h exp=%h", c, rd_addr1, rd_data1, model_rd(rd_addr1, 1)); end
            n_checks++; if (rd_data2 !== model_rd(rd_addr2, 1)) begin n_errors++; $display("FAIL rnd_rd2 cyc=%0d a=%0d got=%h exp=%h", c, rd_addr2, rd_data2, model_rd(rd_addr2, 1)); end
            n_checks++; if (nb_rd_data2 !== model_rd(rd_addr2, 0)) begin n_errors++; $display("FAIL rnd_nb_rd2 cyc=%0d a=%0d got=%h exp=%h", c, rd_addr2, nb_rd_data2, model_rd(rd_addr2, 0)); end
            n_checks++; if (rd_busy1 !== pend[rd_addr1]) begin n_errors++; $display("FAIL rnd_busy1 cyc=%0d a=%0d got=%b exp=%b", c, rd_addr1, rd_busy1, pend[rd_addr1]); end
            n_checks++; if (rd_busy2 !== pend[rd_addr2]) begin n_errors++; $display("FAIL rnd_busy2 cyc=%0d a=%0d got=%b exp=%b", c, rd_addr2, rd_busy2, pend[rd_addr2]); end
            n_checks++; if (busy_cnt !== model_cnt()) begin n_errors++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", c, busy_cnt, model_cnt()); end
            n_checks++; if (nb_busy_cnt !== model_cnt()) begin n_errors++; $display("FAIL rnd_nb_cnt cyc=%0d got=%0d exp=%0d", c, nb_busy_cnt, model_cnt()); end
            tick();
        end
        idle();
    endtask

    initial begin
        rd_addr1 = 0; rd_addr2 = 0;
        test_reset();
        test_async_reset();
        test_write_read();
        test_zero_reg();
        test_collision();
        test_scoreboard();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; depth = 2**ADDR_W.
REQ-003 Parameter ZERO_REG, default 1; when 1, register 0 reads 0 and ignores writes.
REQ-004 Parameter BYPASS, default 1; when 1, same-cycle write data is forwarded to read ports.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 rd_addr1, rd_addr2  in  ADDR_W  read port addresses.
REQ-008 rd_data1, rd_data2  out  DATA_W  read data, combinational from address and state.
REQ-009 rd_busy1, rd_busy2  out  1  pending (scoreboard) bit of the addressed register.
REQ-010 wa_en, wa_addr, wa_data  in  1/ADDR_W/DATA_W  write port A, ALU writeback.
REQ-011 wb_en, wb_addr, wb_data  in  1/ADDR_W/DATA_W  write port B, load writeback.
REQ-012 claim_en, claim_addr  in  1/ADDR_W  marks destination register pending at issue.
REQ-013 busy_cnt  out  ADDR_W+1  number of registers currently pending.

Function
REQ-014 Writes SHALL commit on the rising clk edge when the port enable is 1; no write occurs without an edge.
REQ-015 wa_en and wb_en to the same address in the same cycle: port B data SHALL be stored.
REQ-016 wa_en and wb_en to different addresses: both SHALL be stored in that edge.
REQ-017 With ZERO_REG=1: writes to address 0 SHALL be dropped; rd_data for address 0 SHALL be 0; claims of address 0 SHALL be ignored; rd_busy for address 0 SHALL be 0.
REQ-018 With BYPASS=1: rd_dataN SHALL equal the data of an enabled write to rd_addrN in the current cycle (port B priority), else stored value; address 0 excluded when ZERO_REG=1.
REQ-019 With BYPASS=0: rd_dataN SHALL equal the stored value only; new data visible the cycle after the edge.
REQ-020 Pending bit SHALL set on the edge where claim_en=1 for that address.
REQ-021 Pending bit SHALL clear on the edge where an enabled write (port A or B) targets that address.
REQ-022 Claim and write to the same address in one cycle: pending SHALL remain set (new producer wins); data is still written.
REQ-023 Claim of an already-pending register SHALL leave it pending; busy_cnt unchanged.
REQ-024 Write to a non-pending register SHALL store data; pending stays 0; busy_cnt unchanged.
REQ-025 rd_busyN SHALL reflect stored pending bits only (no same-cycle bypass of claims or clears).
REQ-026 busy_cnt SHALL equal the population count of pending bits, updated in the same edge as the bits; range 0..2**ADDR_W (2**ADDR_W-1 with ZERO_REG=1); no wrap.
REQ-027 Out-of-range or X addresses are not permitted; no internal checking required.
REQ-028 No file I/O or simulation-only tasks SHALL be used for storage or initialisation.

Reset
REQ-029 rst=1 SHALL immediately, without a clk edge, clear all registers to 0, all pending bits to 0, busy_cnt to 0.
REQ-030 While rst=1, writes and claims SHALL be ignored; rd_data outputs show 0 (bypass disabled during reset).
REQ-031 Reset asserted mid-operation SHALL discard any in-flight claim/write of that cycle; first update after release on the first rising edge with rst=0.

Verification
REQ-032 Reset: pulse rst between edges after loading r5=0x1234 -> rd_data1(r5)=0 and busy_cnt=0 before next edge.
REQ-033 Write/read: wa writes r3=0xDEADBEEF; rd_addr1=3 same cycle -> 0xDEADBEEF with BYPASS=1, old value 0 with BYPASS=0; both 0xDEADBEEF next cycle.
REQ-034 Zero register: wa writes r0=0xFFFFFFFF and claim r0 -> rd_data1(r0)=0, rd_busy1=0, busy_cnt=0.
REQ-035 Port collision: wa r7=0x11, wb r7=0x22 same edge -> r7=0x22; wa r8=0x33, wb r9=0x44 -> both stored.
REQ-036 Scoreboard: claim r4 -> rd_busy(r4)=1, busy_cnt=1; next cycle wb writes r4 while claim r4 -> still busy, busy_cnt=1, data updated; then wa writes r4 -> busy 0, busy_cnt=0.
REQ-037 Saturation: claim every register 1..31 over 31 cycles -> busy_cnt=31; release all -> 0.
